// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: LSU FSM encoding, RV32I load/store funct3 codes,
// mem_ctrl access-width codes and small decode helpers.
package cpu_defs_pkg;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // mem_ctrl width code is access size in bytes minus one
    localparam logic [1:0] RAM_SZ_BYTE = 2'd0;
    localparam logic [1:0] RAM_SZ_HALF = 2'd1;
    localparam logic [1:0] RAM_SZ_WORD = 2'd3;

    function automatic logic [1:0] ram_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   ram_size = RAM_SZ_BYTE;
            2'b01:   ram_size = RAM_SZ_HALF;
            default: ram_size = RAM_SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (ram_size(f3))
            RAM_SZ_HALF: misaligned = a[0];
            RAM_SZ_WORD: misaligned = (a != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result formatter: selects byte/half/word from the raw
// mem_ctrl data and sign- or zero-extends it according to funct3.
module load_extend
    import cpu_defs_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

    always_comb begin
        case (funct3_i)
            F3_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_LBU:  ext_o = {24'h0, raw_i[7:0]};
            F3_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_LHU:  ext_o = {16'h0, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one memory request at a time to mem_ctrl over a
// toggle handshake and writes back load results. Optional: LSU_ALIGN_CHECK_EN.
module load_store_unit
    import cpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        op_valid_i,
    input  logic        op_load_i,
    input  logic        op_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        ram_r_req_o,
    output logic        ram_w_req_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic [1:0]  ram_state_o,
    output logic        ram_sync_o,
    input  logic        ram_sync_i,
    input  logic [31:0] ram_data_i
`ifdef LSU_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    lsu_state_e  state_q, state_d;
    logic        sync_q, sync_d;
    logic        r_req_q, r_req_d, w_req_q, w_req_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        is_mem, misal;
    logic [31:0] ext;

    load_extend u_ext (
        .funct3_i (f3_q),
        .raw_i    (ram_data_i),
        .ext_o    (ext)
    );

    assign is_mem = op_load_i | op_store_i;
`ifdef LSU_ALIGN_CHECK_EN
    assign misal = is_mem & misaligned(funct3_i, addr_i[1:0]);
`else
    assign misal = 1'b0;
`endif

    // A rejected misaligned op must not stall, or EX would re-present it forever
    assign stall_o = (state_q == LSU_WAIT) | (op_valid_i & is_mem & ~misal);

    always_comb begin
        state_d    = state_q;
        sync_d     = sync_q;
        r_req_d    = r_req_q;
        w_req_d    = w_req_q;
        addr_d     = addr_q;
        data_d     = data_q;
        size_d     = size_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (op_valid_i) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_i;
                        wb_data_d  = wdata_i;
                    end else if (misal) begin
                        misalign_d = 1'b1;
                    end else begin
                        // load wins when both kinds are flagged
                        addr_d  = addr_i;
                        data_d  = wdata_i;
                        size_d  = ram_size(funct3_i);
                        f3_d    = funct3_i;
                        r_req_d = op_load_i;
                        w_req_d = ~op_load_i;
                        rd_d    = op_load_i ? rd_i : 5'd0;
                        sync_d  = ~sync_q;
                        state_d = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                if (ram_sync_i == sync_q) begin
                    state_d    = LSU_IDLE;
                    r_req_d    = 1'b0;
                    w_req_d    = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = r_req_q ? ext : 32'h0;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            sync_q     <= 1'b0;
            r_req_q    <= 1'b0;
            w_req_q    <= 1'b0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            size_q     <= 2'd0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            r_req_q    <= r_req_d;
            w_req_q    <= w_req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            size_q     <= size_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    // Pulses are masked while frozen so a held register cannot retire twice
    assign wb_valid_o  = wb_valid_q & rdy_in;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign ram_r_req_o = r_req_q;
    assign ram_w_req_o = w_req_q;
    assign ram_addr_o  = addr_q;
    assign ram_data_o  = data_q;
    assign ram_state_o = size_q;
    assign ram_sync_o  = sync_q;
`ifdef LSU_ALIGN_CHECK_EN
    assign misalign_o  = misalign_q & rdy_in;
`endif

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have these ports: clk input 1, clock; rst input 1, reset, asynchronous, active-high.
REQ-002 rdy_in input 1; global ready; low freezes all state.
REQ-003 op_valid_i input 1; EX stage presents an operation.
REQ-004 op_load_i / op_store_i input 1 each; memory op kind; both low = pass-through.
REQ-005 funct3_i input 3; RV32I load/store width code.
REQ-006 addr_i input 32; effective address.
REQ-007 wdata_i input 32; store data, or ALU result for pass-through.
REQ-008 rd_i input 5; destination register.
REQ-009 stall_o output 1; EX must hold its operation while high.
REQ-010 wb_valid_o output 1; one-cycle writeback pulse.
REQ-011 wb_rd_o output 5; writeback register (0 for stores).
REQ-012 wb_data_o output 32; writeback value.
REQ-013 ram_r_req_o / ram_w_req_o output 1 each; read/write request to mem_ctrl.
REQ-014 ram_addr_o output 32; ram_data_o output 32; ram_state_o output 2 (bytes-1: 0 byte, 1 half, 3 word).
REQ-015 ram_sync_o output 1; request toggle. ram_sync_i input 1; completion toggle from mem_ctrl. ram_data_i input 32; load data, valid when sync matches.

Function
REQ-016 FSM states SHALL be IDLE, WAIT; an operation is accepted when op_valid_i=1 and state=IDLE.
REQ-017 Pass-through ops SHALL produce wb_valid_o=1, wb_rd_o=rd_i, wb_data_o=wdata_i one cycle after acceptance; state stays IDLE.
REQ-018 Memory ops SHALL, on the accept edge, register addr/data/state, drive exactly one of r_req/w_req, toggle ram_sync_o, enter WAIT.
REQ-019 ram_state_o SHALL be 0 for funct3[1:0]=00, 1 for 01, 3 otherwise.
REQ-020 stall_o SHALL be combinationally high in WAIT, and in IDLE when a memory op is presented.
REQ-021 Request outputs SHALL hold stable throughout WAIT; the request is pending while ram_sync_o != ram_sync_i.
REQ-022 On the first clk edge in WAIT with ram_sync_i==ram_sync_o: return to IDLE, deassert both req lines, pulse wb_valid_o next cycle.
REQ-023 Load result: LB sign-extends ram_data_i[7:0]; LBU zero-extends [7:0]; LH sign-extends [15:0]; LHU zero-extends [15:0]; LW and reserved codes take all 32 bits; upper stale bits SHALL be ignored.
REQ-024 Store completion SHALL pulse wb_valid_o with wb_rd_o=0, wb_data_o=0.
REQ-025 Loads with rd_i=0 SHALL still be issued and SHALL complete with wb_rd_o=0.
REQ-026 op_load_i and op_store_i both high SHALL be treated as load.
REQ-027 A new op SHALL NOT be accepted in the same cycle a completion is detected; minimum spacing is one IDLE cycle.
REQ-028 rdy_in=0 SHALL hold state, outputs and ram_sync_o; wb_valid_o forced 0.

Reset
REQ-029 rst SHALL asynchronously force IDLE, ram_sync_o=0, all req/wb outputs 0, address/data/state outputs 0, including mid-WAIT; the in-flight op is dropped.

Configuration
REQ-030 With LSU_ALIGN_CHECK_EN defined, a half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL not be issued; output misalign_o (1 bit, reset 0) pulses one cycle, wb_valid_o stays 0, state stays IDLE.
REQ-031 Without LSU_ALIGN_CHECK_EN, misalign_o SHALL not exist and misaligned accesses SHALL be issued unchanged.

Structure
REQ-032 FSM encodings, funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW) and ram_state width codes SHALL reside in shared package cpu_defs_pkg.
REQ-033 Extension logic SHALL be sub-module load_extend (funct3, raw 32 -> extended 32), combinational.

Verification
REQ-034 LB addr=0x100, responder returns 0x000000F0 after 4 cycles -> stall_o high 4+ cycles, ram_state_o=0, wb_data_o=0xFFFFFFF0.
REQ-035 LHU addr=0x102, data 0xABCD8001 -> ram_state_o=1, wb_data_o=0x00008001.
REQ-036 SW addr=0x200, wdata=0x12345678 -> ram_w_req_o=1, ram_data_o=0x12345678, ram_state_o=3, wb_rd_o=0 pulse on completion.
REQ-037 Pass-through rd=5, wdata=0x7 -> wb_valid_o next cycle, wb_rd_o=5, no sync toggle.
REQ-038 rst asserted mid-WAIT -> immediate IDLE, ram_sync_o=0, stall_o=0; rdy_in=0 during WAIT -> outputs frozen, no wb pulse.
REQ-039 LSU_ALIGN_CHECK_EN: LW addr=0x103 -> misalign_o pulse, no req, ram_sync_o unchanged.
